// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns a stream of PS/2 set-2 bytes into per-key held state plus a queue
//   of make/break events for a configurable table of keys.
//
//   Ports:
//     clk           system clock
//     reset         asynchronous, active-low reset
//     datos[7:0]    received byte, valid while rx_done_tick=1
//     rx_done_tick  one-cycle strobe marking a new byte
//     key_state     bit i = 1 while key i is held
//     evt_valid     event FIFO not empty
//     evt_data      head event {brk, idx}; brk=1 for a release
//     evt_rd        pop the head event (ignored while evt_valid=0)
//     evt_overflow  sticky: an event was dropped on a full FIFO
//
//   Build option: define TYPEMATIC_FILTER_EN to suppress events that would
//   not change key_state (typematic repeats and stray breaks).
//
//   Key table layout: key i lives in KEY_CODES[8i+7:8i], so the default
//   literal is written highest key first (key 0 = 8'h29 in the low byte).
module ps2_scancode_decoder #(
    parameter int                    NUM_KEYS  = 8,
    parameter int                    IDX_W     = 3,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {8'h72, 8'h75, 8'h25, 8'h26,
                                                  8'h1E, 8'h16, 8'h5A, 8'h29},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT   = 8'hC0,
    parameter int                    EVT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          datos,
    input  logic                rx_done_tick,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    output logic [IDX_W:0]      evt_data,
    input  logic                evt_rd,
    output logic                evt_overflow
);

    localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t state, state_nx;

    // Cleared by reset, set on the first clock after release: the tick that
    // coincides with the release edge is discarded.
    logic armed;
    logic tick;
    assign tick = rx_done_tick & armed;

    logic             cur_brk, cur_ext;
    logic             code_vld;
    logic             match;
    logic [IDX_W-1:0] match_idx;

    assign cur_brk = (state == BRK) || (state == EXT_BRK);
    assign cur_ext = (state == EXT) || (state == EXT_BRK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        code_vld = 1'b0;
        if (tick) begin
            if (datos == 8'hE0) begin
                case (state)
                    IDLE:    state_nx = EXT;
                    BRK:     state_nx = EXT_BRK;
                    default: state_nx = state;
                endcase
            end else if (datos == 8'hF0) begin
                case (state)
                    IDLE:    state_nx = BRK;
                    EXT:     state_nx = EXT_BRK;
                    default: state_nx = state;
                endcase
            end else begin
                code_vld = 1'b1;
                state_nx = IDLE;
            end
        end
    end

    // Scan high to low so the lowest matching index is the last assignment.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (datos == KEY_CODES[8*i +: 8] && cur_ext == KEY_EXT[i]) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Decode stage: holds the matched key for one cycle before it is applied.
    logic             hit_vld, hit_brk;
    logic [IDX_W-1:0] hit_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_vld <= 1'b0;
            hit_brk <= 1'b0;
            hit_idx <= '0;
        end else begin
            hit_vld <= code_vld & match;
            hit_brk <= cur_brk;
            hit_idx <= match_idx;
        end
    end

    logic push;
`ifdef TYPEMATIC_FILTER_EN
    // Only a state change is an event: make on a released key, break on a held one.
    assign push = hit_vld && (key_state[hit_idx] == hit_brk);
`else
    assign push = hit_vld;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       key_state          <= '0;
        else if (hit_vld) key_state[hit_idx] <= ~hit_brk;
    end

    // Event FIFO. A pop frees a slot in the same cycle, so a push into a
    // full FIFO alongside a pop is accepted.
    logic [IDX_W:0] mem [EVT_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, pop, push_ok;

    assign full     = (count == (AW+1)'(EVT_DEPTH));
    assign evt_valid = (count != '0);
    assign pop      = evt_rd && evt_valid;
    assign push_ok  = push && (!full || pop);
    assign evt_data = evt_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {hit_brk, hit_idx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed byte sequences, with expected
// events queued by the stimulus and checked by an independent monitor.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] datos = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [7:0] key_state;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_rd = 1'b1;
    logic       evt_overflow;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_scancode_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .datos        (datos),
        .rx_done_tick (rx_done_tick),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_rd       (evt_rd),
        .evt_overflow (evt_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_rd) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_pop: got %0h expected none (queue empty)", evt_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL evt_pop: got %0h expected %0h", evt_data, e);
                end
            end
        end
    end

    // Byte is sampled on the first posedge after the call.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        datos = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        while ((exp_q.size() != 0 || evt_valid) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_left"}, exp_q.size(), 0);
        chk({nm, "_valid"}, evt_valid, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_keys"}, key_state, 0);
        chk({nm, "_valid"}, evt_valid, 0);
        chk({nm, "_data"}, evt_data, 0);
        chk({nm, "_ovf"}, evt_overflow, 0);
    endtask

    initial begin
        // Reset state, then a tick on the release edge must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        datos = 8'h29;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("release_tick_keys", key_state, 0);
        chk("release_tick_valid", evt_valid, 0);

        // 1E make / break with one-cycle latency after the sampling edge.
        exp_q.push_back(4'b0_011);
        send_byte(8'h1E);
        @(negedge clk);
        chk("make3_before", key_state[3], 0);
        @(posedge clk); #1;
        chk("make3_after", key_state[3], 1);
        exp_q.push_back(4'b1_011);
        send_byte(8'hF0);
        send_byte(8'h1E);
        @(negedge clk);
        chk("brk3_before", key_state[3], 1);
        @(posedge clk); #1;
        chk("brk3_after", key_state[3], 0);
        wait_drain("k3");

        // Extended key 6, repeated prefixes, and unmatched bytes.
        exp_q.push_back(4'b0_110);
        send_byte(8'hE0); send_byte(8'h75);
        repeat (2) @(posedge clk); #1;
        chk("make6", key_state, 8'h40);
        exp_q.push_back(4'b1_110);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h75);                                   // plain 75: no key
        exp_q.push_back(4'b0_110);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
        exp_q.push_back(4'b1_110);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hEE);
        send_byte(8'hFE); send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hE0); send_byte(8'h29);                 // key 0 is not extended
        repeat (2) @(posedge clk); #1;
        chk("unmatched_keys", key_state, 0);
        wait_drain("k6");

        // Typematic repeats of key 0 and a stray break.
        exp_q.push_back(4'b0_000);
`ifndef TYPEMATIC_FILTER_EN
        exp_q.push_back(4'b0_000);
        exp_q.push_back(4'b0_000);
`endif
        send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
        exp_q.push_back(4'b1_000);
        send_byte(8'hF0); send_byte(8'h29);
`ifndef TYPEMATIC_FILTER_EN
        exp_q.push_back(4'b1_000);
`endif
        send_byte(8'hF0); send_byte(8'h29);
        wait_drain("typematic");

        // Fill the FIFO, push+pop on full, then overflow.
        evt_rd = 1'b0;
        exp_q.push_back(4'b0_000); send_byte(8'h29);
        exp_q.push_back(4'b0_001); send_byte(8'h5A);
        exp_q.push_back(4'b0_010); send_byte(8'h16);
        exp_q.push_back(4'b0_011); send_byte(8'h1E);
        repeat (2) @(posedge clk); #1;
        chk("full_head", evt_data, 4'b0_000);
        exp_q.push_back(4'b0_100);
        send_byte(8'h26);
        evt_rd = 1'b1;                                      // pop lands with the push
        @(posedge clk); #1;
        evt_rd = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("pushpop_ovf", evt_overflow, 0);
        chk("pushpop_head", evt_data, 4'b0_001);
        send_byte(8'h25);                                   // dropped
        repeat (2) @(posedge clk); #1;
        chk("ovf_flag", evt_overflow, 1);
        chk("ovf_keys", key_state, 8'h3F);
        chk("ovf_head_stable", evt_data, 4'b0_001);
        evt_rd = 1'b1;
        wait_drain("wrap");
        chk("ovf_sticky", evt_overflow, 1);

        // Reset in the middle of an E0 F0 prefix.
        send_byte(8'hE0); send_byte(8'hF0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(4'b0_001);
        send_byte(8'h5A);
        repeat (2) @(posedge clk); #1;
        chk("post_rst_keys", key_state, 8'h02);
        wait_drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
